// File: rtl/fft_stage_sequencer.sv
// FFT stage sequencer: steps an address generator through FFT_N radix-2
// stages. Each stage runs RUN -> DRAIN -> NEXT; the final stage ends in DONE.
// The sequencer also toggles the ping-pong bank select and raises a sticky
// timeout flag when a stage hangs.
module fft_stage_sequencer #(
  parameter int FFT_N          = 10,
  parameter int PIPE_LAT       = 4,
  parameter int TIMEOUT_MARGIN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       gen_done,
  output logic [4:0] stage_count,
  output logic       should_run,
  output logic       bank_sel,
  output logic       busy,
  output logic       stage_done,
  output logic       fft_done,
  output logic       timeout_err
);

  localparam int              HALF       = 1 << (FFT_N - 1);
  localparam int              WD_LIMIT   = HALF + 1 + TIMEOUT_MARGIN;
  localparam int              WD_W       = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(WD_LIMIT - 1);
  localparam logic [3:0]      DRAIN_LAST = 4'(PIPE_LAT - 1);
  localparam logic [4:0]      LAST_STAGE = 5'(FFT_N - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    NEXT,
    DONE
  } state_t;

  state_t          state;
  state_t          nextState;
  logic [WD_W-1:0] wdCnt;
  logic [3:0]      drainCnt;
  logic            accept;
  logic            advance;
  logic            hang;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state and output decode. Abort is checked first in every busy
  // state, so it outranks gen_done, the watchdog and the drain count.
  // The pulse outputs are gated by abort in the same cycle.
  always_comb begin
    nextState  = state;
    accept     = 1'b0;
    advance    = 1'b0;
    hang       = 1'b0;
    should_run = 1'b0;
    busy       = 1'b0;
    stage_done = 1'b0;
    fft_done   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept    = 1'b1;
          nextState = RUN;
        end
      end
      RUN: begin
        busy       = 1'b1;
        should_run = 1'b1;
        if (abort)                nextState = IDLE;
        else if (gen_done)        nextState = DRAIN;
        else if (wdCnt == WD_LAST) begin
          hang      = 1'b1;
          nextState = IDLE;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (abort) nextState = IDLE;
        else if (drainCnt == DRAIN_LAST) begin
          stage_done = 1'b1;
          if (stage_count == LAST_STAGE) nextState = DONE;
          else begin
            advance   = 1'b1;
            nextState = NEXT;
          end
        end
      end
      NEXT: begin
        busy = 1'b1;
        if (abort) nextState = IDLE;
        else       nextState = RUN;
      end
      DONE: begin
        busy = 1'b1;
        if (!abort) fft_done = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Watchdog, drain counter, stage index, bank select and sticky timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdCnt       <= '0;
      drainCnt    <= '0;
      stage_count <= '0;
      bank_sel    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wdCnt    <= (state == RUN)   ? wdCnt + 1'b1    : '0;
      drainCnt <= (state == DRAIN) ? drainCnt + 1'b1 : '0;
      if (accept) begin
        stage_count <= '0;
        bank_sel    <= 1'b0;
        timeout_err <= 1'b0;
      end else if (advance) begin
        stage_count <= stage_count + 1'b1;
        bank_sel    <= ~bank_sel;
      end
      if (hang) timeout_err <= 1'b1;
    end
  end

endmodule
